arb4_sched: RTL and testbench

Four-requester bus arbiter and scheduler for one shared resource. It wraps the 4-to-2 priority-encoding function in a clocked controller. It selects one requester, holds the grant while that requester keeps its request up, and enforces a maximum hold time. It supports fixed-priority (y3 > y2 > y1 > y0) and round-robin modes, and sits between the requesting units and the shared datapath mux, whose select is `gnt_id`.

---
 rtl/arb4_sched.sv | 93 +++++++++
 tb/tb_arb4_sched.sv | 98 +++++++++
 2 files changed

// File: rtl/arb4_sched.sv
// Four-requester arbiter for one shared resource: fixed-priority or round-robin
// selection, grant held while requested, capped at MAX_HOLD consecutive cycles.
module arb4_sched #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       mode,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);
    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [1:0]    own;
    logic [1:0]    last;
    logic [CW-1:0] cnt;

    logic       expire;
    logic       release_own;
    logic [3:0] cand;
    logic       arb;
    logic [1:0] winner;

    // Round-robin scans descending offsets so the smallest offset from last+1 lands last.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic rr, input logic [1:0] lst);
        logic [1:0] w;
        logic [1:0] idx;
        w = 2'd0;
        if (rr) begin
            for (int i = 3; i >= 0; i--) begin
                idx = lst + 2'(i + 1);
                if (r[idx]) w = idx;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r[i]) w = 2'(i);
            end
        end
        return w;
    endfunction

    always_comb begin
        expire      = (state == BUSY) && req[own] && (cnt == CNT_MAX);
        release_own = (state == BUSY) && !req[own];
        cand        = req & ~(4'b0001 << own);
        arb         = ((state == IDLE) && (req != 4'b0000)) || expire || (release_own && (cand != 4'b0000));
        if (state == IDLE)
            winner = pick(req, mode, last);
        else if (cand != 4'b0000)
            winner = pick(cand, mode, last);
        else
            winner = own;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            own       <= 2'd0;
            last      <= 2'd3;
            cnt       <= '0;
            gnt       <= 4'b0000;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= expire;
            if (arb) begin
                state     <= BUSY;
                own       <= winner;
                last      <= winner;
                cnt       <= '0;
                gnt       <= 4'b0001 << winner;
                gnt_id    <= winner;
                gnt_valid <= 1'b1;
            end else if (state == BUSY && req[own]) begin
                cnt <= cnt + 1'b1;
            end else if (state == BUSY) begin
                state     <= IDLE;
                cnt       <= '0;
                gnt       <= 4'b0000;
                gnt_id    <= 2'd0;
                gnt_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_arb4_sched.sv
// Directed bench for arb4_sched with MAX_HOLD=4; outputs checked 1ns after each rising edge.
module tb_arb4_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       mode = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int total = 0;
    int bad = 0;

    arb4_sched #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compares {gnt, gnt_id, gnt_valid, timeout} against the expected tuple.
    task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                       input logic ev, input logic eto);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {gnt, gnt_id, gnt_valid, timeout};
        exp = {eg, eid, ev, eto};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got gnt=%b id=%0d valid=%b timeout=%b, want gnt=%b id=%0d valid=%b timeout=%b",
                   tag, obs[7:4], obs[3:2], obs[1], obs[0], eg, eid, ev, eto);
        end
    endtask

    task automatic do_reset(input logic m);
        rst_n = 1'b0; req = 4'b0000; mode = m;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state and fixed-priority pick of the highest request
        do_reset(1'b0);
        chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b1111; step(); chk("fix_first", 4'b1000, 2'd3, 1'b1, 1'b0);
        // Hand-off chain with no idle bubble
        req = 4'b0110; step(); chk("fix_handoff2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0010; step(); chk("fix_handoff1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0001; step(); chk("fix_handoff0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000; step(); chk("fix_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Round-robin rotation, each owner holds two cycles
        do_reset(1'b1);
        req = 4'b1111; step(); chk("rr_0", 4'b0001, 2'd0, 1'b1, 1'b0);
        step();                chk("rr_0_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b1110; step(); chk("rr_1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1111; step(); chk("rr_1_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1101; step(); chk("rr_2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b1111; step(); chk("rr_2_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b1011; step(); chk("rr_3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b1111; step(); chk("rr_3_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0111; step(); chk("rr_wrap0", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Hold-limit expiry hands over to the other requester; no preemption before that
        do_reset(1'b0);
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            step(); chk($sformatf("hold_own2_c%0d", k), 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        step(); chk("expire_to0", 4'b0001, 2'd0, 1'b1, 1'b1);
        step(); chk("expire_pulse_end", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Single requester: same-owner re-grant every 4 cycles, grant never drops
        do_reset(1'b0);
        req = 4'b0010;
        for (int k = 0; k < 9; k++) begin
            step();
            chk($sformatf("solo_c%0d", k), 4'b0010, 2'd1, 1'b1, (k != 0) && (k % 4 == 0));
        end

        // Reset mid-grant drops everything; round-robin restarts at index 0
        do_reset(1'b1);
        req = 4'b0100; step(); chk("rr_grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
        rst_n = 1'b0;  step(); chk("midreset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1; req = 4'b1111; step(); chk("post_reset_rr0", 4'b0001, 2'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
